// File: rtl/tlb_lookup.sv
// Fully associative joint TLB: one-cycle translation of mapped addresses plus
// TLBWI/TLBWR entry writes and TLBP probes against independent compare logic.
module tlb_lookup #(
    parameter int unsigned NUM_ENTRIES = 16,
    parameter int unsigned IDX_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lookup_en,
    input  logic [31:0]      vaddr,
    input  logic             is_store,
    input  logic [7:0]       cur_asid,
    output logic             lookup_valid,
    output logic [31:0]      paddr,
    output logic             uncached,
    output logic             tlb_miss,
    output logic             tlb_invalid,
    output logic             tlb_modified,
    input  logic             tlb_we,
    input  logic [IDX_W-1:0] tlb_index,
    input  logic [31:0]      entry_hi,
    input  logic [31:0]      entry_lo0,
    input  logic [31:0]      entry_lo1,
    input  logic             probe_en,
    output logic             probe_done,
    output logic [31:0]      probe_result
);

    localparam int unsigned VPN2_W = 19;
    localparam int unsigned PFN_W  = 20;

    logic [VPN2_W-1:0] e_vpn2 [NUM_ENTRIES];
    logic [7:0]        e_asid [NUM_ENTRIES];
    logic              e_g    [NUM_ENTRIES];
    logic              e_w    [NUM_ENTRIES];
    logic [PFN_W-1:0]  e_pfn0 [NUM_ENTRIES];
    logic [PFN_W-1:0]  e_pfn1 [NUM_ENTRIES];
    logic [2:0]        e_c0   [NUM_ENTRIES];
    logic [2:0]        e_c1   [NUM_ENTRIES];
    logic              e_d0   [NUM_ENTRIES];
    logic              e_d1   [NUM_ENTRIES];
    logic              e_v0   [NUM_ENTRIES];
    logic              e_v1   [NUM_ENTRIES];

    // Fields of the CP0 words that the TLB does not store.
    logic unused_fields;
    assign unused_fields = &{1'b0, entry_hi[12:8], entry_lo0[31:26], entry_lo1[31:26]};

    logic             idx_ok;
    assign idx_ok = 32'(tlb_index) < NUM_ENTRIES;

    // Entry storage; reset invalidates every entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
                e_vpn2[i] <= '0;
                e_asid[i] <= '0;
                e_g[i]    <= 1'b0;
                e_w[i]    <= 1'b0;
                e_pfn0[i] <= '0;
                e_pfn1[i] <= '0;
                e_c0[i]   <= '0;
                e_c1[i]   <= '0;
                e_d0[i]   <= 1'b0;
                e_d1[i]   <= 1'b0;
                e_v0[i]   <= 1'b0;
                e_v1[i]   <= 1'b0;
            end
        end else if (tlb_we && idx_ok) begin
            e_vpn2[tlb_index] <= entry_hi[31:13];
            e_asid[tlb_index] <= entry_hi[7:0];
            e_g[tlb_index]    <= entry_lo0[0] & entry_lo1[0];
            e_w[tlb_index]    <= 1'b1;
            e_pfn0[tlb_index] <= entry_lo0[25:6];
            e_pfn1[tlb_index] <= entry_lo1[25:6];
            e_c0[tlb_index]   <= entry_lo0[5:3];
            e_c1[tlb_index]   <= entry_lo1[5:3];
            e_d0[tlb_index]   <= entry_lo0[2];
            e_d1[tlb_index]   <= entry_lo1[2];
            e_v0[tlb_index]   <= entry_lo0[1];
            e_v1[tlb_index]   <= entry_lo1[1];
        end
    end

    logic             l_hit_c;
    logic [IDX_W-1:0] l_idx_c;
    logic             p_hit_c;
    logic [IDX_W-1:0] p_idx_c;

    // Two independent CAM searches; scanning downward lets the lowest index win.
    always_comb begin
        l_hit_c = 1'b0;
        l_idx_c = '0;
        p_hit_c = 1'b0;
        p_idx_c = '0;
        for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
            if (e_w[i] && e_vpn2[i] == vaddr[31:13] &&
                (e_g[i] || e_asid[i] == cur_asid)) begin
                l_hit_c = 1'b1;
                l_idx_c = IDX_W'(i);
            end
            if (e_w[i] && e_vpn2[i] == entry_hi[31:13] &&
                (e_g[i] || e_asid[i] == entry_hi[7:0])) begin
                p_hit_c = 1'b1;
                p_idx_c = IDX_W'(i);
            end
        end
    end

    logic [PFN_W-1:0] sel_pfn_c;
    logic [2:0]       sel_c_c;
    logic             sel_d_c;
    logic             sel_v_c;

    // Even/odd page select within the matched pair.
    always_comb begin
        sel_pfn_c = e_pfn0[l_idx_c];
        sel_c_c   = e_c0[l_idx_c];
        sel_d_c   = e_d0[l_idx_c];
        sel_v_c   = e_v0[l_idx_c];
        if (vaddr[12]) begin
            sel_pfn_c = e_pfn1[l_idx_c];
            sel_c_c   = e_c1[l_idx_c];
            sel_d_c   = e_d1[l_idx_c];
            sel_v_c   = e_v1[l_idx_c];
        end
    end

    // Result registers; paddr and flags hold between lookups.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lookup_valid <= 1'b0;
            paddr        <= '0;
            uncached     <= 1'b0;
            tlb_miss     <= 1'b0;
            tlb_invalid  <= 1'b0;
            tlb_modified <= 1'b0;
        end else begin
            lookup_valid <= lookup_en;
            if (lookup_en) begin
                paddr        <= l_hit_c ? {sel_pfn_c, vaddr[11:0]} : 32'h0;
                uncached     <= l_hit_c && (sel_c_c == 3'b010);
                tlb_miss     <= !l_hit_c;
                tlb_invalid  <= l_hit_c && !sel_v_c;
                tlb_modified <= l_hit_c && sel_v_c && !sel_d_c && is_store;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            probe_done   <= 1'b0;
            probe_result <= '0;
        end else begin
            probe_done <= probe_en;
            if (probe_en) begin
                probe_result <= p_hit_c ? 32'(p_idx_c) : 32'h8000_0000;
            end
        end
    end

endmodule

// File: tb/tb_tlb_lookup.sv
// Randomized and directed checks of tlb_lookup against a table-based reference
// that keeps the raw CP0 words per entry and decodes them on every search.
module tb_tlb_lookup;

    localparam int unsigned N     = 16;
    localparam int unsigned IDX_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             lookup_en;
    logic [31:0]      vaddr;
    logic             is_store;
    logic [7:0]       cur_asid;
    logic             lookup_valid;
    logic [31:0]      paddr;
    logic             uncached;
    logic             tlb_miss;
    logic             tlb_invalid;
    logic             tlb_modified;
    logic             tlb_we;
    logic [IDX_W-1:0] tlb_index;
    logic [31:0]      entry_hi;
    logic [31:0]      entry_lo0;
    logic [31:0]      entry_lo1;
    logic             probe_en;
    logic             probe_done;
    logic [31:0]      probe_result;

    tlb_lookup #(.NUM_ENTRIES(N), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst),
        .lookup_en(lookup_en), .vaddr(vaddr), .is_store(is_store), .cur_asid(cur_asid),
        .lookup_valid(lookup_valid), .paddr(paddr), .uncached(uncached),
        .tlb_miss(tlb_miss), .tlb_invalid(tlb_invalid), .tlb_modified(tlb_modified),
        .tlb_we(tlb_we), .tlb_index(tlb_index), .entry_hi(entry_hi),
        .entry_lo0(entry_lo0), .entry_lo1(entry_lo1),
        .probe_en(probe_en), .probe_done(probe_done), .probe_result(probe_result)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference table: raw register images as software wrote them.
    bit        m_w   [N];
    bit [31:0] m_hi  [N];
    bit [31:0] m_lo0 [N];
    bit [31:0] m_lo1 [N];

    // Expected held outputs.
    bit [31:0] e_paddr;
    bit [3:0]  e_flags;
    bit [31:0] e_pres;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit [31:0] mk_lo(input bit [19:0] pfn, input bit [2:0] c,
                                        input bit d, input bit v, input bit g);
        return {6'b0, pfn, c, d, v, g};
    endfunction

    function automatic int m_find(input bit [31:0] hi_like, input bit [7:0] asid);
        for (int i = 0; i < int'(N); i++) begin
            bit glob;
            glob = m_lo0[i][0] && m_lo1[i][0];
            if (m_w[i] && m_hi[i][31:13] == hi_like[31:13] && (glob || m_hi[i][7:0] == asid))
                return i;
        end
        return -1;
    endfunction

    // Expected {uncached, miss, invalid, modified} and paddr of one translation.
    task automatic m_lookup(input bit [31:0] va, input bit [7:0] asid, input bit st,
                            output bit [31:0] pa, output bit [3:0] fl);
        int        k;
        bit [31:0] lo;
        k = m_find(va, asid);
        if (k < 0) begin
            pa = 0;
            fl = 4'b0100;
        end else begin
            lo = va[12] ? m_lo1[k] : m_lo0[k];
            pa = {lo[25:6], va[11:0]};
            fl[3] = (lo[5:3] == 3'd2);
            fl[2] = 1'b0;
            fl[1] = !lo[1];
            fl[0] = lo[1] && !lo[2] && st;
        end
    endtask

    function automatic bit [31:0] m_probe(input bit [31:0] hi);
        int k;
        k = m_find(hi, hi[7:0]);
        return (k < 0) ? 32'h8000_0000 : 32'(k);
    endfunction

    task automatic m_clear();
        for (int i = 0; i < int'(N); i++) begin
            m_w[i] = 0; m_hi[i] = 0; m_lo0[i] = 0; m_lo1[i] = 0;
        end
        e_paddr = 0; e_flags = 0; e_pres = 0;
    endtask

    task automatic wr(input int idx, input bit [31:0] hi, input bit [31:0] lo0, input bit [31:0] lo1);
        tlb_we = 1'b1; tlb_index = IDX_W'(idx);
        entry_hi = hi; entry_lo0 = lo0; entry_lo1 = lo1;
    endtask

    task automatic lk(input bit [31:0] va, input bit [7:0] asid, input bit st);
        lookup_en = 1'b1; vaddr = va; cur_asid = asid; is_store = st;
    endtask

    task automatic pr(input bit [31:0] hi);
        probe_en = 1'b1; entry_hi = hi;
    endtask

    // One clock: expectations from pre-edge table state, then the write lands.
    task automatic cycle(input string tag);
        bit le, pe;
        le = lookup_en;
        pe = probe_en;
        if (le) m_lookup(vaddr, cur_asid, is_store, e_paddr, e_flags);
        if (pe) e_pres = m_probe(entry_hi);
        @(posedge clk);
        #1;
        if (tlb_we) begin
            m_w[tlb_index] = 1; m_hi[tlb_index] = entry_hi;
            m_lo0[tlb_index] = entry_lo0; m_lo1[tlb_index] = entry_lo1;
        end
        check({tag, ".valid"}, 32'(lookup_valid), 32'(le));
        check({tag, ".paddr"}, paddr, e_paddr);
        check({tag, ".flags"}, 32'({uncached, tlb_miss, tlb_invalid, tlb_modified}), 32'(e_flags));
        check({tag, ".pdone"}, 32'(probe_done), 32'(pe));
        check({tag, ".presult"}, probe_result, e_pres);
        lookup_en = 1'b0; probe_en = 1'b0; tlb_we = 1'b0;
    endtask

    initial begin
        bit [18:0] vp;
        rst = 1'b1; lookup_en = 0; vaddr = 0; is_store = 0; cur_asid = 0;
        tlb_we = 0; tlb_index = 0; entry_hi = 0; entry_lo0 = 0; entry_lo1 = 0; probe_en = 0;
        m_clear();
        repeat (3) @(posedge clk);
        #1;
        check("reset.outputs", {paddr[31:2], lookup_valid, probe_done},
              32'h0);
        check("reset.flags", 32'({uncached, tlb_miss, tlb_invalid, tlb_modified}), 32'h0);
        rst = 1'b0;

        lk(32'h0000_0000, 8'h00, 0);                                   cycle("empty_miss");

        wr(3, 32'h0040_2005, mk_lo(20'h12345, 3, 1, 1, 0), mk_lo(20'h54321, 3, 1, 1, 0));
        cycle("wr3");
        lk(32'h0040_2ABC, 8'h05, 0);                                   cycle("hit3");
        check("hit3.const_paddr", paddr, 32'h1234_5ABC);
        lk(32'h0040_2ABC, 8'h06, 0);                                   cycle("asid_miss");

        wr(3, 32'h0040_2005, mk_lo(20'h12345, 3, 1, 1, 0), mk_lo(20'h54321, 3, 1, 0, 0));
        cycle("wr3_v0");
        lk(32'h0040_3000, 8'h05, 0);                                   cycle("invalid");
        wr(3, 32'h0040_2005, mk_lo(20'h12345, 3, 0, 1, 0), mk_lo(20'h54321, 3, 1, 0, 0));
        cycle("wr3_d0");
        lk(32'h0040_2000, 8'h05, 1);                                   cycle("modified");
        lk(32'h0040_2000, 8'h05, 0);                                   cycle("load_ok");

        wr(9, 32'h0080_0009, mk_lo(20'hAAAAA, 2, 1, 1, 1), mk_lo(20'hBBBBB, 2, 1, 1, 1));
        cycle("wr9_global");
        lk(32'h0080_1123, 8'h77, 0);                                   cycle("global_unc");
        wr(1, 32'h0100_0000, mk_lo(20'h11111, 3, 1, 1, 0), mk_lo(20'h11112, 3, 1, 1, 0));
        cycle("wr1_dup");
        wr(7, 32'h0100_0000, mk_lo(20'h77777, 3, 1, 1, 0), mk_lo(20'h77778, 3, 1, 1, 0));
        cycle("wr7_dup");
        lk(32'h0100_0456, 8'h00, 0);                                   cycle("dup_low_idx");

        wr(5, 32'h0200_0000, mk_lo(20'h55555, 3, 1, 1, 0), mk_lo(20'h55556, 3, 1, 1, 0));
        lk(32'h0200_0010, 8'h00, 0);                                   cycle("collide_old");
        lk(32'h0200_0010, 8'h00, 0);                                   cycle("collide_new");
        cycle("idle_hold");

        pr(32'h0040_2005);                                             cycle("probe_hit");
        pr(32'h0FF0_0000);                                             cycle("probe_miss");
        lk(32'h0040_2010, 8'h05, 0); pr(32'h0080_0001);                cycle("lk_and_probe");

        // Random mix over a small VPN/ASID pool so hits, aliases and misses all occur.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                bit g;
                g  = ($urandom_range(0, 3) == 0);
                vp = 19'h100 + 19'($urandom_range(0, 5));
                wr(int'($urandom_range(0, N - 1)), {vp, 5'b0, 8'($urandom_range(1, 2))},
                   mk_lo(20'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), g),
                   mk_lo(20'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), g));
            end
            if ($urandom_range(0, 9) < 7) begin
                vp = 19'h100 + 19'($urandom_range(0, 6));
                lk({vp, 13'($urandom)}, 8'($urandom_range(1, 3)), 1'($urandom));
            end
            if ($urandom_range(0, 9) < 3 && !tlb_we) begin
                vp = 19'h100 + 19'($urandom_range(0, 6));
                pr({vp, 5'b0, 8'($urandom_range(1, 3))});
            end
            cycle("rand");
        end

        // Reset arriving while a lookup is in flight.
        @(negedge clk);
        lk(32'h0040_2ABC, 8'h05, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_drop.valid", 32'(lookup_valid), 32'h0);
        check("rst_drop.paddr", paddr, 32'h0);
        m_clear();
        lookup_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        pr(32'h0040_2005);                                             cycle("probe_after_rst");
        check("probe_after_rst.const", probe_result, 32'h8000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tlb_lookup.md
Name: tlb_lookup

Overview:
- Fully associative joint TLB. Sits directly downstream of the virtual memory map stage.
- Consumes mapped-segment requests (kuseg/kseg2/kseg3, where the map stage asserts using_tlb). Produces a registered physical address plus TLB exception flags for the memory-access stage.
- Supports CP0 TLBWI/TLBWR writes and TLBP probes.

Parameters:
- NUM_ENTRIES, 16, number of TLB entries; must be a power of two, at most 32.
- IDX_W, 4, index width; equals log2(NUM_ENTRIES).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- lookup_en  in  1  translate vaddr this cycle (driven by using_tlb from the map stage)
- vaddr  in  32  virtual address
- is_store  in  1  access is a store (used for the dirty check)
- cur_asid  in  8  current ASID (CP0 EntryHi[7:0])
- lookup_valid  out  1  result registers hold a new result
- paddr  out  32  translated physical address
- uncached  out  1  selected page has C==3'b010
- tlb_miss  out  1  no entry matched
- tlb_invalid  out  1  matched, but selected V==0
- tlb_modified  out  1  matched, V==1, D==0, is_store==1
- tlb_we  in  1  write entry
- tlb_index  in  IDX_W  entry to write
- entry_hi  in  32  VPN2 in [31:13], ASID in [7:0]
- entry_lo0  in  32  PFN in [25:6], C in [5:3], D in [2], V in [1], G in [0]; even page
- entry_lo1  in  32  same layout; odd page
- probe_en  in  1  TLBP request, using entry_hi
- probe_done  out  1  probe result valid
- probe_result  out  32  bit31 = P (1 on miss); IDX_W LSBs = matching index; other bits 0

Behaviour:
- Storage per entry: VPN2[18:0], ASID[7:0], G, PFN0/C0/D0/V0, PFN1/C1/D1/V1, plus an internal written flag.
- Reset clears all storage, all written flags and all outputs to 0. An unwritten entry never matches.
- Write:
  - On a clk edge with tlb_we=1, the entry at tlb_index is loaded and its written flag is set.
  - G = entry_lo0[0] & entry_lo1[0].
  - tlb_index >= NUM_ENTRIES is ignored.
- Match rule: written && VPN2 == vaddr[31:13] && (G || ASID == cur_asid). Probe uses entry_hi[31:13] and entry_hi[7:0] in place of vaddr and cur_asid.
- Multiple matches: the lowest index wins. Software must not create them, but the result is deterministic.
- Page select: vaddr[12]==0 selects lo0, ==1 selects lo1. 4 KB pages.
- Lookup latency is one cycle.
  - Inputs are sampled at edge N; outputs are valid after edge N+1 and held until the next lookup edge.
  - lookup_valid is a one-cycle pulse.
- Flag rules:
  - Exactly one of tlb_miss / tlb_invalid / tlb_modified may be set, with priority miss > invalid > modified.
  - On miss: paddr=0, uncached=0.
  - On invalid: paddr is still computed.
- paddr = {PFN[19:0], vaddr[11:0]}.
- Cycles with lookup_en=0: lookup_valid=0. paddr and flags hold their previous values, but flags must be qualified by lookup_valid downstream.
- Write/lookup collision: a lookup at the same edge as a write to the matching entry sees the OLD contents. The new contents are visible from the next edge on. The same rule applies to probe.
- Probe:
  - One-cycle latency; probe_done pulses.
  - On hit: probe_result = {1'b0, zeros, idx}.
  - On miss: probe_result = 32'h8000_0000.
  - Lookup and probe may occur in the same cycle; they use independent compare logic.
- Reset asserted mid-lookup drops the pending result: lookup_valid=0 in the following cycle, and all entries are invalidated.
- No internal state machine beyond the result pipeline registers. Back-to-back lookups every cycle are supported (throughput 1/cycle).

Test Plan:
- Reset, then lookup_en=1, vaddr=32'h0000_0000 -> next cycle lookup_valid=1, tlb_miss=1, paddr=0.
- Write idx 3: hi=32'h0040_2005, lo0={PFN 20'h12345, C=3, D=1, V=1, G=0}. Lookup vaddr=32'h0040_2ABC, asid=5 -> paddr=32'h1234_5ABC, no flags, uncached=0. Same lookup with asid=6 -> tlb_miss=1.
- Same entry with lo1 V=0. Lookup vaddr=32'h0040_3000 -> tlb_invalid=1. Set lo0 D=0 and store to 32'h0040_2000 -> tlb_modified=1. Load from the same address -> no flags.
- G=1 in both lo0 and lo1, C=2, any asid -> hit with uncached=1. Duplicate VPN2 in idx 1 and idx 7 -> idx 1's PFN is used.
- Write idx 5 and lookup its VPN at the same edge -> miss. Repeat the lookup next cycle -> hit.
- Probe entry_hi=32'h0040_2005 -> probe_result=32'h0000_0003. Probe an unknown VPN -> 32'h8000_0000. Assert rst during a pending lookup -> lookup_valid=0 and a subsequent probe misses.
